fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS core; feeds the decode-stage control unit.
- Owns the PC, talks to instruction memory over a request/ready handshake, and applies stall (WPCIR) and redirect (jump/branch/JR) from decode.
- Uses MIPS delay-slot semantics with no flush. A redirect that arrives before the delay slot has been fetched is held pending.

---
 rtl/fetch_stage_pkg.sv | 17 +
 rtl/fetch_stage_if.sv | 24 ++
 rtl/fetch_stage_next_pc_select.sv | 37 +++
 rtl/fetch_stage.sv | 131 +++++++++++++
 tb/tb_fetch_stage.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Fetch FSM encoding, bubble word, reset PC and branch offset helper.
package fetch_stage_pkg;

   typedef enum logic {
      FETCH_STATE_FETCH = 1'b0,
      FETCH_STATE_HOLD  = 1'b1
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTRUCTION  = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready handshake between fetch and imem.
// The fetch side drives address and request; memory returns the word.
interface fetch_stage_if;

   logic [31:0] imemAddress;
   logic        imemRequest;
   logic        imemReady;
   logic [31:0] imemInstruction;

   modport master (
      output imemAddress,
      output imemRequest,
      input  imemReady,
      input  imemInstruction
   );

   modport slave (
      input  imemAddress,
      input  imemRequest,
      output imemReady,
      output imemInstruction
   );

endinterface

// File: rtl/fetch_stage_next_pc_select.sv
// Redirect target and next-PC selection for the fetch stage.
// Purely combinational; the fetch stage owns all state.
module fetch_stage_next_pc_select
   import fetch_stage_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic [31:0] id_pc4_i,
   input  logic [25:0] id_index_i,
   input  logic [29:0] rs_word_i,
   input  logic        is_jr_i,
   input  logic        is_j_i,
   input  logic        redirect_i,
   input  logic        pend_valid_i,
   input  logic [31:0] pend_target_i,
   output logic [31:0] target_o,
   output logic [31:0] next_pc_o
);

   always_comb begin
      target_o = id_pc4_i + branch_offset(id_index_i[15:0]);
      if (is_jr_i) begin
         target_o = {rs_word_i, 2'b00};
      end else if (is_j_i) begin
         target_o = {id_pc4_i[31:28], id_index_i, 2'b00};
      end
   end

   always_comb begin
      next_pc_o = pc_i + 32'd4;
      if (redirect_i) begin
         next_pc_o = target_o;
      end else if (pend_valid_i) begin
         next_pc_o = pend_target_i;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch plus IF/ID register with delay-slot redirects.
// A redirect seen before its delay slot arrives is parked as pending.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic          clock,
   input  logic          reset_n,
   fetch_stage_if.master imem,
   input  logic          shouldStall,
   input  logic          shouldJumpOrBranch,
   input  logic          isJumpIndex,
   input  logic          isJumpRegister,
   input  logic [31:0]   registerRs,
   output logic [31:0]   idInstruction,
   output logic [31:0]   idPc_4,
   output logic          idValid
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  buf_q, buf_d;
   logic         pend_valid_q, pend_valid_d;
   logic [31:0]  pend_target_q, pend_target_d;
   logic [31:0]  id_instr_q, id_instr_d;
   logic [31:0]  id_pc4_q, id_pc4_d;
   logic         id_valid_q, id_valid_d;

   logic        in_fetch;
   logic        advance;
   logic        deliver;
   logic        redirect;
   logic [31:0] word;
   logic [31:0] target;
   logic [31:0] next_pc;

   assign in_fetch = (state_q == FETCH_STATE_FETCH);
   assign advance  = !shouldStall;
   assign deliver  = advance &&
                     ((in_fetch && imem.imemReady) || !in_fetch);
   assign redirect = shouldJumpOrBranch && id_valid_q && advance;
   assign word     = in_fetch ? imem.imemInstruction : buf_q;

   // Reset gates the request so an outstanding fetch is dropped at once.
   assign imem.imemRequest = reset_n && in_fetch;
   assign imem.imemAddress = pc_q;

   assign idInstruction = id_instr_q;
   assign idPc_4        = id_pc4_q;
   assign idValid       = id_valid_q;

   fetch_stage_next_pc_select u_next_pc (
      .pc_i          (pc_q),
      .id_pc4_i      (id_pc4_q),
      .id_index_i    (id_instr_q[25:0]),
      .rs_word_i     (registerRs[31:2]),
      .is_jr_i       (isJumpRegister),
      .is_j_i        (isJumpIndex),
      .redirect_i    (redirect),
      .pend_valid_i  (pend_valid_q),
      .pend_target_i (pend_target_q),
      .target_o      (target),
      .next_pc_o     (next_pc)
   );

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      buf_d         = buf_q;
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;
      id_instr_d    = id_instr_q;
      id_pc4_d      = id_pc4_q;
      id_valid_d    = id_valid_q;

      unique case (state_q)
         FETCH_STATE_FETCH: begin
            if (imem.imemReady && !advance) begin
               buf_d   = imem.imemInstruction;
               state_d = FETCH_STATE_HOLD;
            end
         end
         FETCH_STATE_HOLD: begin
            if (advance) begin
               state_d = FETCH_STATE_FETCH;
            end
         end
      endcase

      if (deliver) begin
         id_instr_d   = word;
         id_pc4_d     = pc_q + 32'd4;
         id_valid_d   = 1'b1;
         pc_d         = next_pc;
         pend_valid_d = 1'b0;
      end else if (advance) begin
         // Bubble keeps the sequence address so decode sees a sane PC+4.
         id_instr_d = NOP_INSTRUCTION;
         id_pc4_d   = pc_q;
         id_valid_d = 1'b0;
         if (redirect) begin
            pend_valid_d  = 1'b1;
            pend_target_d = target;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= FETCH_STATE_FETCH;
         pc_q          <= RESET_PC;
         buf_q         <= '0;
         pend_valid_q  <= 1'b0;
         pend_target_q <= '0;
         id_instr_q    <= NOP_INSTRUCTION;
         id_pc4_q      <= '0;
         id_valid_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         buf_q         <= buf_d;
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
         id_instr_q    <= id_instr_d;
         id_pc4_q      <= id_pc4_d;
         id_valid_q    <= id_valid_d;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: program-order model plus random traffic.
// The driver predicts each cycle's IF/ID result; a monitor compares it.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   typedef struct {
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        req;
      logic [31:0] addr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ready = 1'b0;
   logic        shouldStall = 1'b0;
   logic        shouldJumpOrBranch = 1'b0;
   logic        isJumpIndex = 1'b0;
   logic        isJumpRegister = 1'b0;
   logic [31:0] registerRs = '0;
   logic [31:0] idInstruction;
   logic [31:0] idPc_4;
   logic        idValid;

   int checks = 0;
   int errors = 0;

   exp_t        sb_q[$];
   logic [31:0] exp_q[$];
   bit          m_valid;
   logic [31:0] m_word;
   logic [31:0] m_pc4;
   bit          have_word;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0020) return 32'h1000_0004;
      if (a == 32'h8000_0000) return 32'h0800_0040;
      return {6'b100011, a[27:2] ^ 26'h2A5_5A5A};
   endfunction

   function automatic logic [31:0] model_target(
      input bit jr, input bit j, input logic [31:0] rs,
      input logic [31:0] w, input logic [31:0] pc4);
      if (jr) return rs & ~32'h3;
      if (j) return {pc4[31:28], w[25:0], 2'b00};
      return pc4 + (32'($signed(w[15:0])) << 2);
   endfunction

   fetch_stage_if imem_if ();

   assign imem_if.imemReady       = ready;
   assign imem_if.imemInstruction = mem_word(imem_if.imemAddress);

   fetch_stage #(.RESET_PC(RESET_PC)) dut (
      .clock              (clk),
      .reset_n            (rst_n),
      .imem               (imem_if),
      .shouldStall        (shouldStall),
      .shouldJumpOrBranch (shouldJumpOrBranch),
      .isJumpIndex        (isJumpIndex),
      .isJumpRegister     (isJumpRegister),
      .registerRs         (registerRs),
      .idInstruction      (idInstruction),
      .idPc_4             (idPc_4),
      .idValid            (idValid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         chk("idValid", 32'(idValid), 32'(e.valid));
         chk("idInstruction", idInstruction, e.instr);
         chk("idPc_4", idPc_4, e.pc4);
         chk("imemRequest", 32'(imem_if.imemRequest), 32'(e.req));
         chk("imemAddress", imem_if.imemAddress, e.addr);
      end
   end

   task automatic model_reset();
      m_valid   = 1'b0;
      m_word    = '0;
      m_pc4     = '0;
      have_word = 1'b0;
      exp_q.delete();
      exp_q.push_back(RESET_PC);
   endtask

   task automatic do_reset();
      rst_n              = 1'b0;
      ready              = 1'b1;
      shouldStall        = 1'b0;
      shouldJumpOrBranch = 1'b0;
      isJumpIndex        = 1'b0;
      isJumpRegister     = 1'b0;
      #1;
      chk("req_in_reset", 32'(imem_if.imemRequest), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      #1;
      chk("rst_idValid", 32'(idValid), 32'h0);
      chk("rst_idInstruction", idInstruction, 32'h0);
      chk("rst_idPc_4", idPc_4, 32'h0);
      chk("rst_imemAddress", imem_if.imemAddress, RESET_PC);
      chk("rst_imemRequest", 32'(imem_if.imemRequest), 32'h1);
   endtask

   // One clock of stimulus; the model advances in program order.
   task automatic step(input bit stall, input bit rdy, input bit br,
                       input bit j, input bit jr, input logic [31:0] rs);
      bit          redirect;
      bit          fetched;
      logic [31:0] a;
      exp_t        e;
      shouldStall        = stall;
      ready              = rdy;
      shouldJumpOrBranch = br;
      isJumpIndex        = j;
      isJumpRegister     = jr;
      registerRs         = rs;
      redirect = br && m_valid && !stall;
      if (redirect) begin
         checks++;
         assert (exp_q.size() == 1)
         else begin
            errors++;
            $display("FAIL pending_redirect queue=%0d required=1",
                     exp_q.size());
         end
         exp_q.push_back(model_target(jr, j, rs, m_word, m_pc4));
      end
      fetched = !have_word && rdy;
      if (!stall) begin
         if (have_word || fetched) begin
            a         = exp_q.pop_front();
            m_word    = mem_word(a);
            m_pc4     = a + 32'd4;
            m_valid   = 1'b1;
            have_word = 1'b0;
            if (exp_q.size() == 0) exp_q.push_back(a + 32'd4);
         end else begin
            m_word  = '0;
            m_pc4   = exp_q[0];
            m_valid = 1'b0;
         end
      end else if (fetched) begin
         have_word = 1'b1;
      end
      e.valid = m_valid;
      e.instr = m_word;
      e.pc4   = m_pc4;
      e.req   = !have_word;
      e.addr  = exp_q[0];
      sb_q.push_back(e);
      @(negedge clk);
   endtask

   initial begin
      model_reset();
      do_reset();

      repeat (4) step(0, 1, 0, 0, 0, '0);
      chk("addr_before_wait", imem_if.imemAddress, 32'h10);
      step(0, 0, 0, 0, 0, '0);
      step(0, 0, 0, 0, 0, '0);
      step(0, 1, 0, 0, 0, '0);
      chk("pc4_after_wait", idPc_4, 32'h14);
      step(1, 1, 0, 0, 0, '0);
      chk("hold_drops_req", 32'(imem_if.imemRequest), 32'h0);
      step(1, 0, 0, 0, 0, '0);
      step(1, 1, 0, 0, 0, '0);
      step(0, 0, 0, 0, 0, '0);
      chk("held_word_pc4", idPc_4, 32'h18);
      repeat (3) step(0, 1, 0, 0, 0, '0);
      step(0, 1, 1, 0, 0, '0);
      chk("beq_delay_slot", idPc_4, 32'h28);
      chk("beq_target", imem_if.imemAddress, 32'h34);
      step(0, 1, 0, 0, 0, '0);
      step(0, 0, 1, 0, 1, 32'h0000_1003);
      step(0, 0, 0, 0, 0, '0);
      chk("jr_pc_on_slot", imem_if.imemAddress, 32'h38);
      step(0, 1, 0, 0, 0, '0);
      chk("jr_pending_used", imem_if.imemAddress, 32'h1000);
      step(0, 1, 0, 0, 0, '0);
      step(0, 1, 1, 0, 1, 32'h8000_0000);
      step(0, 1, 0, 0, 0, '0);
      step(0, 1, 1, 1, 0, '0);
      chk("j_target", imem_if.imemAddress, 32'h8000_0100);
      step(0, 1, 0, 0, 0, '0);

      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(3) == 0, $urandom_range(2) != 0,
              $urandom_range(3) == 0, 1'($urandom), 1'($urandom),
              $urandom);
      end

      do_reset();
      repeat (16) step(0, 1, 0, 0, 0, '0);
      step(0, 0, 0, 0, 0, '0);
      chk("addr_mid_fetch", imem_if.imemAddress, 32'h40);
      do_reset();
      repeat (4) step(0, 1, 0, 0, 0, '0);

      @(posedge clk);
      #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
